// File: rtl/stim_ctrl_pkg.sv
// Shared types and helpers for the closed-loop stimulation vote controller.
// Holds the FSM state encoding, the default per-channel threshold, the
// vote-count width helper and a popcount used to tally channel votes.
package stim_ctrl_pkg;

    // Controller phases: gather samples, score the epoch, pulse, lock out
    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_EVAL,
        ST_STIM,
        ST_REFRACT
    } stim_state_t;

    // Threshold value the feature channels are normally configured with
    localparam longint DEFAULT_THRESH = 1000;

    // Widest feature vector the popcount helper has to handle
    localparam int MAX_FEAT = 8;

    // Bits needed to hold a vote total of 0..num_feat
    function automatic int vote_width(input int num_feat);
        return $clog2(num_feat + 1);
    endfunction

    // Number of set bits in a (zero-padded) vote vector
    function automatic logic [3:0] popcount(input logic [MAX_FEAT-1:0] bits);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_FEAT; i++) begin
            cnt = cnt + {3'b000, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/stim_vote_ctrl_collect.sv
// feat_epoch_collect: per-channel epoch gatherer.
// Compares each strobed feature sample against its signed threshold, keeps a
// seen bit and a vote bit per channel, and runs the epoch timer that starts
// with the first accepted sample.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   accept       high while the controller is collecting; strobes otherwise dropped
//   clear        wipes seen/votes/timer (epoch has been evaluated)
//   din          packed signed samples, channel i at [i*DATA_W +: DATA_W]
//   din_valid    per-channel sample strobe
//   thresh       packed signed per-channel thresholds
//   all_seen     every channel will have reported once this edge's strobes land
//   timed_out    the epoch timer will have reached TIMEOUT after this edge
//   votes        registered vote bits of the current epoch
module feat_epoch_collect
    import stim_ctrl_pkg::*;
#(
    parameter int NUM_FEAT = 3,
    parameter int DATA_W   = 40,
    parameter int TIMEOUT  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         accept,
    input  logic                         clear,
    input  logic [NUM_FEAT*DATA_W-1:0]   din,
    input  logic [NUM_FEAT-1:0]          din_valid,
    input  logic [NUM_FEAT*DATA_W-1:0]   thresh,
    output logic                         all_seen,
    output logic                         timed_out,
    output logic [NUM_FEAT-1:0]          votes
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [NUM_FEAT-1:0] seen_q, seen_d;
    logic [NUM_FEAT-1:0] votes_q, votes_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [NUM_FEAT-1:0] above_thr;

    // Strict signed comparison of every channel against its own threshold
    always_comb begin
        above_thr = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            above_thr[i] = $signed(din[i*DATA_W +: DATA_W]) >
                           $signed(thresh[i*DATA_W +: DATA_W]);
        end
    end

    // Latch strobed channels (a repeat strobe simply overwrites the vote) and
    // advance the timer; the timer value is "cycles open including this edge",
    // so the first sample loads 1.
    always_comb begin
        seen_d  = seen_q;
        votes_d = votes_q;
        timer_d = timer_q;
        if (clear) begin
            seen_d  = '0;
            votes_d = '0;
            timer_d = '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_FEAT; i++) begin
                if (din_valid[i]) begin
                    seen_d[i]  = 1'b1;
                    votes_d[i] = above_thr[i];
                end
            end
            if (|seen_q) begin
                timer_d = timer_q + TMR_W'(1);
            end else if (|din_valid) begin
                timer_d = TMR_W'(1);
            end
        end
    end

    // Close conditions look at the next-state values so the controller can
    // move to evaluation on the same edge that completes the epoch.
    always_comb begin
        all_seen  = accept && (&seen_d);
        timed_out = accept && (timer_d >= TMR_W'(TIMEOUT));
        votes     = votes_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q  <= '0;
            votes_q <= '0;
            timer_q <= '0;
        end else begin
            seen_q  <= seen_d;
            votes_q <= votes_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/stim_vote_ctrl.sv
// stim_vote_ctrl: majority-vote seizure detector with closed-loop stimulation.
// Gathers one thresholded sample per feature channel per epoch, reports the
// vote total, and after CONSEC consecutive positive epochs drives a STIM_LEN
// cycle stimulation pulse followed by a REFRACT cycle lockout.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   din             packed signed feature samples, channel i at [i*DATA_W +: DATA_W]
//   din_valid       per-channel sample strobe
//   thresh          packed signed per-channel thresholds (quasi-static)
//   decision_valid  one-cycle pulse per evaluated epoch
//   vote_count      votes of the last evaluated epoch (held until the next)
//   epoch_timeout   set with decision_valid when the epoch closed on timeout
//   stimulation     stimulator enable
//   busy            high during the pulse and the refractory lockout
module stim_vote_ctrl
    import stim_ctrl_pkg::*;
#(
    parameter int NUM_FEAT = 3,
    parameter int DATA_W   = 40,
    parameter int VOTE_MIN = 2,
    parameter int CONSEC   = 2,
    parameter int STIM_LEN = 4,
    parameter int REFRACT  = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_FEAT*DATA_W-1:0]        din,
    input  logic [NUM_FEAT-1:0]               din_valid,
    input  logic [NUM_FEAT*DATA_W-1:0]        thresh,
    output logic                              decision_valid,
    output logic [$clog2(NUM_FEAT+1)-1:0]     vote_count,
    output logic                              epoch_timeout,
    output logic                              stimulation,
    output logic                              busy
);

    localparam int VC_W    = vote_width(NUM_FEAT);
    localparam int CS_W    = $clog2(CONSEC + 1);
    localparam int CNT_MAX = (STIM_LEN > REFRACT) ? STIM_LEN : REFRACT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    stim_state_t          state_q, state_d;
    logic [CS_W-1:0]      consec_q, consec_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 to_flag_q, to_flag_d;
    logic                 decision_valid_q, decision_valid_d;
    logic [VC_W-1:0]      vote_count_q, vote_count_d;
    logic                 epoch_timeout_q, epoch_timeout_d;

    logic                 all_seen;
    logic                 timed_out;
    logic [NUM_FEAT-1:0]  votes;
    logic [MAX_FEAT-1:0]  votes_pad;

    feat_epoch_collect #(
        .NUM_FEAT (NUM_FEAT),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT)
    ) u_collect (
        .clk       (clk),
        .rst       (rst),
        .accept    (state_q == ST_COLLECT),
        .clear     (state_q == ST_EVAL),
        .din       (din),
        .din_valid (din_valid),
        .thresh    (thresh),
        .all_seen  (all_seen),
        .timed_out (timed_out),
        .votes     (votes)
    );

    // Epoch scoring, consecutive-positive tracking and pulse/lockout sequencing.
    // An epoch that completes on the very edge its timer expires is reported
    // as complete, not as a timeout.
    always_comb begin
        state_d          = state_q;
        consec_d         = consec_q;
        cnt_d            = cnt_q;
        to_flag_d        = to_flag_q;
        decision_valid_d = 1'b0;
        vote_count_d     = vote_count_q;
        epoch_timeout_d  = 1'b0;
        votes_pad        = '0;
        votes_pad[NUM_FEAT-1:0] = votes;

        case (state_q)
            ST_COLLECT: begin
                if (all_seen || timed_out) begin
                    state_d   = ST_EVAL;
                    to_flag_d = timed_out && !all_seen;
                end
            end
            ST_EVAL: begin
                vote_count_d     = VC_W'(popcount(votes_pad));
                decision_valid_d = 1'b1;
                epoch_timeout_d  = to_flag_q;
                to_flag_d        = 1'b0;
                if (vote_count_d >= VC_W'(VOTE_MIN)) begin
                    if (consec_q != CS_W'(CONSEC)) begin
                        consec_d = consec_q + CS_W'(1);
                    end
                end else begin
                    consec_d = '0;
                end
                if (consec_d == CS_W'(CONSEC)) begin
                    state_d = ST_STIM;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_STIM: begin
                consec_d = '0;
                if (cnt_q == CNT_W'(STIM_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = (REFRACT == 0) ? ST_COLLECT : ST_REFRACT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REFRACT: begin
                if ((REFRACT == 0) || (cnt_q == CNT_W'(REFRACT - 1))) begin
                    cnt_d   = '0;
                    state_d = ST_COLLECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_COLLECT;
            consec_q         <= '0;
            cnt_q            <= '0;
            to_flag_q        <= 1'b0;
            decision_valid_q <= 1'b0;
            vote_count_q     <= '0;
            epoch_timeout_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            consec_q         <= consec_d;
            cnt_q            <= cnt_d;
            to_flag_q        <= to_flag_d;
            decision_valid_q <= decision_valid_d;
            vote_count_q     <= vote_count_d;
            epoch_timeout_q  <= epoch_timeout_d;
        end
    end

    assign decision_valid = decision_valid_q;
    assign vote_count     = vote_count_q;
    assign epoch_timeout  = epoch_timeout_q;
    assign stimulation    = (state_q == ST_STIM);
    assign busy           = (state_q == ST_STIM) || (state_q == ST_REFRACT);

endmodule

// File: tb/tb_stim_vote_ctrl.sv
// Self-checking bench for stim_vote_ctrl. A driver issues epochs and pushes the
// expected decision (cycle, vote total, timeout flag, stimulation) into a
// scoreboard; a monitor on the falling edge pops and compares whenever the DUT
// raises decision_valid and tracks the expected pulse/lockout windows.
module tb_stim_vote_ctrl;
   import stim_ctrl_pkg::*;

   localparam int NF = 3;
   localparam int DW = 40;
   localparam int VM = 2;
   localparam int CS = 2;
   localparam int SL = 4;
   localparam int RF = 8;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NF*DW-1:0]  din;
   logic [NF-1:0]     din_valid;
   logic [NF*DW-1:0]  thresh;
   logic              decision_valid;
   logic [1:0]        vote_count;
   logic              epoch_timeout;
   logic              stimulation;
   logic              busy;

   stim_vote_ctrl #(
      .NUM_FEAT (NF), .DATA_W (DW), .VOTE_MIN (VM), .CONSEC (CS),
      .STIM_LEN (SL), .REFRACT (RF), .TIMEOUT (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .din            (din),
      .din_valid      (din_valid),
      .thresh         (thresh),
      .decision_valid (decision_valid),
      .vote_count     (vote_count),
      .epoch_timeout  (epoch_timeout),
      .stimulation    (stimulation),
      .busy           (busy)
   );

   // Free-running clock and an edge counter: cyc == k after the k-th rising edge
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int dec_cyc;
      int vc;
      bit to;
      bit stim;
   } exp_t;
   exp_t sbq[$];

   int errors = 0;
   int checks = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // ---------------- reference model of the epoch/vote rules ----------------
   longint thr[NF];
   longint mval[NF];
   bit     mseen[NF];
   bit     open;
   int     first_edge;
   int     consec_m;
   int     last_dec;
   bit     last_stim;

   task automatic clearEpoch();
      for (int i = 0; i < NF; i++) begin
         mseen[i] = 1'b0;
         mval[i]  = 0;
      end
      open = 1'b0;
   endtask

   // Score the finished epoch and queue the decision the DUT must produce
   task automatic pushExpect(input int dec, input bit to);
      exp_t e;
      int   vc;
      vc = 0;
      for (int i = 0; i < NF; i++) if (mseen[i] && (mval[i] > thr[i])) vc++;
      if (vc >= VM) consec_m = (consec_m + 1 > CS) ? CS : consec_m + 1;
      else consec_m = 0;
      e.dec_cyc = dec;
      e.vc      = vc;
      e.to      = to;
      e.stim    = (consec_m == CS);
      if (e.stim) consec_m = 0;
      sbq.push_back(e);
      last_dec  = dec;
      last_stim = e.stim;
      clearEpoch();
   endtask

   function automatic longint rv();
      case ($urandom_range(0, 6))
         0: return 999;
         1: return 1000;
         2: return 1001;
         3: return longint'($urandom_range(0, 5000)) - 2000;
         4: return -(longint'(1) << 39);
         5: return (longint'(1) << 39) - 1;
         default: return longint'($urandom_range(0, 3000));
      endcase
   endfunction

   // All drive tasks start and end 1ns after a rising edge
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [NF-1:0] mask, input longint v0, input longint v1, input longint v2);
      longint vv[NF];
      int     edge_k;
      vv[0] = v0; vv[1] = v1; vv[2] = v2;
      for (int i = 0; i < NF; i++) begin
         if (mask[i]) din[i*DW +: DW] = vv[i][DW-1:0];
         else begin
            vv[i] = rv();
            din[i*DW +: DW] = vv[i][DW-1:0];
         end
      end
      din_valid = mask;
      @(posedge clk);
      #1;
      edge_k = cyc;
      din_valid = '0;
      if (!open && (mask != '0)) begin
         open = 1'b1;
         first_edge = edge_k;
      end
      for (int i = 0; i < NF; i++) begin
         if (mask[i]) begin
            mseen[i] = 1'b1;
            mval[i]  = vv[i];
         end
      end
      if (mseen[0] && mseen[1] && mseen[2]) pushExpect(edge_k + 1, 1'b0);
   endtask

   task automatic closeByTimeout();
      pushExpect(first_edge + TO, 1'b1);
   endtask

   // Strobes the model knows must be dropped (evaluation, pulse or lockout)
   task automatic driveIgnored(input logic [NF-1:0] mask);
      for (int i = 0; i < NF; i++) din[i*DW +: DW] = 40'd5000;
      din_valid = mask;
      @(posedge clk);
      #1;
      din_valid = '0;
   endtask

   task automatic waitReady(input int gap);
      int target;
      target = last_dec + (last_stim ? SL + RF : 0) + gap;
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearEpoch();
      consec_m  = 0;
      last_stim = 1'b0;
      last_dec  = cyc;
   endtask

   // ---------------- monitor ----------------
   logic rst_edge;
   always @(posedge clk) rst_edge <= rst;

   int   stim_left = 0;
   int   refr_left = 0;
   int   last_vc   = 0;

   // Falling-edge checker: reset values, decisions against the scoreboard,
   // vote_count hold, and the expected stimulation/busy windows
   always @(negedge clk) begin
      exp_t e;
      if (rst_edge === 1'b1) begin
         checkOutput("rst_decision_valid", decision_valid, 0);
         checkOutput("rst_vote_count", vote_count, 0);
         checkOutput("rst_epoch_timeout", epoch_timeout, 0);
         checkOutput("rst_stimulation", stimulation, 0);
         checkOutput("rst_busy", busy, 0);
         sbq.delete();
         stim_left = 0;
         refr_left = 0;
         last_vc   = 0;
      end else begin
         if (decision_valid !== 1'b0) begin
            if (sbq.size() == 0) begin
               checkOutput("unexpected_decision", decision_valid, 0);
            end else begin
               e = sbq.pop_front();
               checkOutput("decision_cycle", cyc, e.dec_cyc);
               checkOutput("vote_count", vote_count, e.vc);
               checkOutput("epoch_timeout", epoch_timeout, e.to);
               last_vc = e.vc;
               if (e.stim) begin
                  stim_left = SL;
                  refr_left = RF;
               end
            end
         end else begin
            checkOutput("vote_count_hold", vote_count, last_vc);
            checkOutput("timeout_idle", epoch_timeout, 0);
            if ((sbq.size() > 0) && (cyc > sbq[0].dec_cyc)) begin
               checkOutput("missed_decision", decision_valid, 1);
               void'(sbq.pop_front());
            end
         end
         checkOutput("stimulation", stimulation, stim_left > 0);
         checkOutput("busy", busy, (stim_left > 0) || (refr_left > 0));
         if (stim_left > 0) stim_left--;
         else if (refr_left > 0) refr_left--;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [NF-1:0] mask;
      int            omit;
      int            nsteps;
      int            steps;

      rst       = 1'b1;
      din       = '0;
      din_valid = '0;
      for (int i = 0; i < NF; i++) begin
         thr[i] = DEFAULT_THRESH;
         thresh[i*DW +: DW] = 40'(DEFAULT_THRESH);
      end
      consec_m  = 0;
      last_stim = 1'b0;
      clearEpoch();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      last_dec = cyc;

      // Two positive epochs in a row trigger a pulse
      waitReady(1);
      applyStimulus(3'b111, 1500, 1200, 10);
      waitReady(0);
      applyStimulus(3'b111, 1500, 1200, 10);

      // Positive, then an equality/negative epoch breaks the run
      waitReady(0);
      applyStimulus(3'b111, 1500, 1200, 10);
      waitReady(0);
      applyStimulus(3'b111, 1000, -5000, 1001);
      waitReady(0);
      applyStimulus(3'b111, 1500, 1200, 10);

      // Staggered arrival completes on the last channel
      waitReady(2);
      applyStimulus(3'b001, 1500, 0, 0);
      idle(4);
      applyStimulus(3'b100, 0, 0, 2000);
      idle(3);
      applyStimulus(3'b010, 0, 1200, 0);

      // Missing channel closes by timeout
      waitReady(0);
      applyStimulus(3'b001, 1500, 0, 0);
      idle(4);
      applyStimulus(3'b100, 0, 0, 2000);
      closeByTimeout();

      // Strobes during evaluation, pulse and lockout are dropped
      waitReady(0);
      applyStimulus(3'b111, 2000, 2000, 2000);
      while (cyc < last_dec + SL + RF) driveIgnored(3'($urandom_range(1, 7)));
      applyStimulus(3'b111, 2000, 2000, 2000);

      // Overwrite: last sample on ch0 wins
      waitReady(0);
      applyStimulus(3'b001, 1500, 0, 0);
      applyStimulus(3'b001, 900, 0, 0);
      applyStimulus(3'b110, 0, 2000, 0);

      // Reset during the second pulse cycle
      waitReady(0);
      applyStimulus(3'b111, 1500, 1200, 10);
      waitReady(0);
      applyStimulus(3'b111, 1500, 1200, 10);
      while (cyc < last_dec + 1) idle(1);
      doReset();
      applyStimulus(3'b111, 1500, 1200, 10);

      // Reset mid-epoch discards the partial epoch
      waitReady(0);
      applyStimulus(3'b011, 2000, 2000, 0);
      doReset();
      applyStimulus(3'b100, 0, 0, 2000);
      closeByTimeout();

      // Randomized epochs: random masks, gaps, repeats and omitted channels
      for (int e = 0; e < 60; e++) begin
         waitReady($urandom_range(0, 2));
         omit   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NF - 1)) : -1;
         nsteps = $urandom_range(1, 3);
         steps  = 0;
         do begin
            if (steps > 0) idle($urandom_range(0, 2));
            mask = 3'($urandom_range(1, 7));
            if (omit >= 0) begin
               mask[omit] = 1'b0;
               if (mask == '0) mask[(omit + 1) % NF] = 1'b1;
            end else if (steps == 3) begin
               for (int i = 0; i < NF; i++) if (!mseen[i]) mask[i] = 1'b1;
            end
            applyStimulus(mask, rv(), rv(), rv());
            steps++;
         end while ((omit < 0) ? open : (steps < nsteps));
         if (omit >= 0) closeByTimeout();
      end

      waitReady(0);
      idle(40);
      checkOutput("scoreboard_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stim_vote_ctrl.md
# stim_vote_ctrl

- Parametrised successor to the fixed three-feature majority controller.
- Collects one sample per feature detector per epoch (line length, power spectrum, nonlinear energy, …) and compares each against a run-time signed threshold.
- Emits a per-epoch vote decision, and drives a closed-loop stimulation pulse after a configurable number of consecutive positive epochs, followed by a refractory lockout.
- Sits between the feature-extraction stages and the stimulator driver.

## Interface
Parameters:
- NUM_FEAT, 3, number of feature channels (1..8)
- DATA_W, 40, signed feature/threshold width
- VOTE_MIN, 2, minimum votes for a positive epoch (1..NUM_FEAT)
- CONSEC, 2, consecutive positive epochs required to stimulate (≥1)
- STIM_LEN, 4, stimulation pulse length in cycles (≥1)
- REFRACT, 8, lockout cycles after a pulse (≥0)
- TIMEOUT, 16, max cycles an epoch may stay open after its first sample (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- din  in  NUM_FEAT*DATA_W  signed feature samples, channel i at bits [i*DATA_W +: DATA_W]
- din_valid  in  NUM_FEAT  per-channel data-ready strobe
- thresh  in  NUM_FEAT*DATA_W  signed per-channel thresholds, quasi-static
- decision_valid  out  1  one-cycle pulse per evaluated epoch
- vote_count  out  $clog2(NUM_FEAT+1)  votes of the last evaluated epoch
- epoch_timeout  out  1  high with decision_valid if the epoch closed by timeout
- stimulation  out  1  stimulation enable
- busy  out  1  high in STIM or REFRACT

## Operation
- Vote rule: channel i votes when din_i > thresh_i, signed, strict. A value equal to the threshold does not vote.
- FSM states: COLLECT, EVAL, STIM, REFRACT.
- COLLECT
  - Each asserted din_valid[i] latches vote bit i and sets seen[i]; simultaneous strobes on several channels are all accepted.
  - A repeated strobe on an already-seen channel overwrites its vote bit (last wins).
  - The epoch timer starts on the first accepted sample.
  - Go to EVAL when seen is all ones or the timer reaches TIMEOUT. Unseen channels count as no-vote.
- EVAL (one cycle)
  - Register vote_count = popcount(votes), pulse decision_valid, and set epoch_timeout if closed by timeout.
  - Clear seen, votes and timer.
  - Positive epoch (vote_count ≥ VOTE_MIN): increment consec_cnt, saturating at CONSEC. Otherwise clear consec_cnt to 0.
  - If consec_cnt reaches CONSEC, go to STIM. Else go to COLLECT.
- STIM: stimulation high for exactly STIM_LEN cycles, then REFRACT; consec_cnt cleared.
- REFRACT: REFRACT cycles, then COLLECT. If REFRACT = 0, go straight from STIM to COLLECT.
- din_valid is ignored in EVAL, STIM and REFRACT. Samples arriving there are dropped and never open an epoch.
- Reset at any time, including mid-epoch or mid-pulse:
  - State goes to COLLECT; seen, votes, timer and consec_cnt are cleared.
  - All outputs go to 0 on the next edge.

## Timing
- Reset values: decision_valid 0, vote_count 0, epoch_timeout 0, stimulation 0, busy 0.
- Last required din_valid sampled at edge t → EVAL during cycle t+1 → decision_valid, vote_count and epoch_timeout high in cycle t+2.
- When triggered, stimulation rises in cycle t+2, the same cycle as decision_valid. It stays high for cycles t+2 .. t+1+STIM_LEN.
- busy is high exactly while stimulation or the refractory lockout is active.
- Timeout: first sample at edge s, epoch still incomplete → EVAL at cycle s+TIMEOUT, decision_valid at s+TIMEOUT+1.
- The earliest new sample accepted after a decision is the edge ending the cycle in which decision_valid is high.
- vote_count holds its value until the next EVAL.

## Structure
- Package stim_ctrl_pkg holds:
  - FSM state enum
  - default threshold constant (1000)
  - popcount function
  - vote-width helper
- One sub-module, feat_epoch_collect: per-channel seen/vote registers, compare, and epoch timer. It exports all_seen, timed_out and the votes vector.
- The FSM, consec counter and pulse/refractory counters live in the top level.

## Test plan
Common settings: NUM_FEAT=3, VOTE_MIN=2, CONSEC=2, STIM_LEN=4, REFRACT=8, TIMEOUT=16, all thresholds 1000.
- Two positive epochs: din = {1500, 1200, 10}, all valid together, twice. → vote_count=2 on both decisions; stimulation high 4 cycles from the second decision_valid; busy high 12 cycles.
- Equality and negatives: din = {1000, -5000, 1001}. → vote_count=1; no stimulation; consec_cnt reset.
- Staggered arrival and timeout:
  - ch0 at cycle 0, ch2 at cycle 5 → EVAL only after ch1 arrives.
  - Omitting ch1 → decision_valid at cycle 17 with epoch_timeout=1.
- Lockout: strobes driven during STIM and REFRACT → no decision_valid until REFRACT has ended; the next epoch is counted from zero.
- Overwrite: ch0 strobed 1500 then 900 in the same epoch → ch0 does not vote.
- Reset mid-STIM at pulse cycle 2 → stimulation 0 on the next edge; the following single positive epoch does not stimulate.
